mem_arbiter: RTL and testbench

Shares the core's single 32-bit memory bus between instruction fetch (IF) and data access (MEM stage loads/stores). It arbitrates by fixed priority and runs one bus transaction at a time through a req/ack handshake. For RV32I loads and stores it generates byte lanes, performs load sign/zero extension and flags misaligned or illegal accesses. It raises stall requests toward the pipeline controller while a requester is waiting.

---
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 556 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority MEM/IF arbiter onto one 32-bit bus.
// Handles RV32I byte lanes, load extension and access checking.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS_IF,
    BUS_MEM,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_mem_q, gnt_mem_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_bad;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        ld_sext;

  always_comb begin
    req_bad   = 1'b0;
    req_sel   = 4'b1111;
    req_wdata = mem_wdata_i;
    unique case (mem_funct3_i[1:0])
      2'd0: begin
        req_sel   = 4'b0001 << mem_addr_i[1:0];
        req_wdata = {4{mem_wdata_i[7:0]}};
      end
      2'd1: begin
        req_sel   = mem_addr_i[1] ? 4'b1100
                                  : 4'b0011;
        req_wdata = {2{mem_wdata_i[15:0]}};
        req_bad   = mem_addr_i[0];
      end
      2'd2: req_bad = |mem_addr_i[1:0];
      default: req_bad = 1'b1;
    endcase
    // unsigned variants exist only for LB/LH loads
    if (mem_funct3_i[2] &&
        (mem_we_i || mem_funct3_i[1]))
      req_bad = 1'b1;
  end

  always_comb begin
    ld_byte = bus_rdata_i[7:0];
    unique case (1'b1)
      off_q == 2'd0: ld_byte = bus_rdata_i[7:0];
      off_q == 2'd1: ld_byte = bus_rdata_i[15:8];
      off_q == 2'd2: ld_byte = bus_rdata_i[23:16];
      off_q == 2'd3: ld_byte = bus_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? bus_rdata_i[31:16]
                       : bus_rdata_i[15:0];
    ld_sext = !f3_q[2];
    unique case (f3_q[1:0])
      2'd0: ld_ext = {{24{ld_sext & ld_byte[7]}},
                      ld_byte};
      2'd1: ld_ext = {{16{ld_sext & ld_half[15]}},
                      ld_half};
      default: ld_ext = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gnt_mem_d = gnt_mem_q;
    err_d     = err_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          gnt_mem_d = 1'b1;
          f3_d      = mem_funct3_i;
          off_d     = mem_addr_i[1:0];
          if (req_bad) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            we_d    = mem_we_i;
            addr_d  = mem_addr_i & 32'hFFFF_FFFC;
            sel_d   = req_sel;
            wdata_d = req_wdata;
            state_d = BUS_MEM;
          end
        end else if (if_req_i) begin
          gnt_mem_d = 1'b0;
          err_d     = 1'b0;
          we_d      = 1'b0;
          addr_d    = if_addr_i & 32'hFFFF_FFFC;
          sel_d     = 4'b1111;
          state_d   = BUS_IF;
        end
      end
      BUS_IF: begin
        if (bus_ack_i) begin
          if_data_d = bus_rdata_i;
          state_d   = RESP;
        end
      end
      BUS_MEM: begin
        if (bus_ack_i) begin
          rdata_d = we_q ? 32'h0 : ld_ext;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_mem_q <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      addr_q    <= 32'h0;
      sel_q     <= 4'h0;
      wdata_q   <= 32'h0;
      if_data_q <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      gnt_mem_q <= gnt_mem_d;
      err_q     <= err_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus_req_o   = (state_q == BUS_IF) ||
                       (state_q == BUS_MEM);
  assign bus_we_o    = bus_req_o && we_q;
  assign bus_addr_o  = addr_q;
  assign bus_sel_o   = sel_q;
  assign bus_wdata_o = wdata_q;

  assign if_ready_o  = (state_q == RESP) && !gnt_mem_q;
  assign mem_ready_o = (state_q == RESP) && gnt_mem_q;
  assign mem_err_o   = mem_ready_o && err_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = rdata_q;

  assign stallreq_if_o  = if_req_i && !if_ready_o;
  assign stallreq_mem_o = mem_req_i && !mem_ready_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus a response scoreboard
// that pops an expected entry on every ready pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        mem_err_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_mem;
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .if_ready_o     (if_ready_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_funct3_i   (mem_funct3_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_ready_o    (mem_ready_o),
    .mem_err_o      (mem_err_o),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_sel_o      (bus_sel_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (if_ready_o || mem_ready_o)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready if=%0b mem=%0b",
                 if_ready_o, mem_ready_o);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_mem) begin
          if (mem_ready_o !== 1'b1 ||
              if_ready_o !== 1'b0 ||
              mem_err_o !== mon_e.err ||
              (mon_e.chk_data &&
               mem_rdata_o !== mon_e.data)) begin
            errors++;
            $display({"FAIL mem_resp got rdy=%0b/%0b ",
                      "err=%0b data=%h exp err=%0b ",
                      "data=%h"},
                     mem_ready_o, if_ready_o, mem_err_o,
                     mem_rdata_o, mon_e.err, mon_e.data);
          end
        end else begin
          if (if_ready_o !== 1'b1 ||
              mem_ready_o !== 1'b0 ||
              if_data_o !== mon_e.data) begin
            errors++;
            $display({"FAIL if_resp got rdy=%0b/%0b ",
                      "data=%h exp data=%h"},
                     if_ready_o, mem_ready_o,
                     if_data_o, mon_e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic is_mem,
                      input logic chk,
                      input logic [31:0] data,
                      input logic err);
    exp_t e;
    e.is_mem   = is_mem;
    e.chk_data = chk;
    e.data     = data;
    e.err      = err;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    if_req_i     = 1'b0;
    if_addr_i    = 32'h0;
    mem_req_i    = 1'b0;
    mem_we_i     = 1'b0;
    mem_funct3_i = 3'd0;
    mem_addr_i   = 32'h0;
    mem_wdata_i  = 32'h0;
    bus_rdata_i  = 32'h0;
    bus_ack_i    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    sample();
    checks++;
    if ({bus_req_o, bus_we_o, if_ready_o,
         mem_ready_o, mem_err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {bus_req_o, bus_we_o, if_ready_o,
                mem_ready_o, mem_err_o});
    end
    checks++;
    if ({bus_addr_o, bus_sel_o, bus_wdata_o} !== 68'h0) begin
      errors++;
      $display("FAIL reset_bus got %h %h %h exp 0",
               bus_addr_o, bus_sel_o, bus_wdata_o);
    end
    checks++;
    if ({if_data_o, mem_rdata_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h exp 0",
               if_data_o, mem_rdata_o);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    step();
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_1003;
    push(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    sample();
    checks++;
    if ({stallreq_if_o, bus_req_o} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_c0 got stall=%0b req=%0b exp 1 0",
               stallreq_if_o, bus_req_o);
    end
    step();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hDEAD_BEEF;
    sample();
    checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 ||
        bus_addr_o !== 32'h0000_1000 ||
        bus_sel_o !== 4'hF || stallreq_if_o !== 1'b1) begin
      errors++;
      $display({"FAIL fetch_c1 got req=%0b we=%0b ",
                "addr=%h sel=%b stall=%0b exp 1 0 ",
                "00001000 1111 1"},
               bus_req_o, bus_we_o, bus_addr_o,
               bus_sel_o, stallreq_if_o);
    end
    step();
    bus_ack_i = 1'b0;
    sample();
    checks++;
    if ({if_ready_o, stallreq_if_o, bus_req_o} !==
        3'b100) begin
      errors++;
      $display("FAIL fetch_c2 got rdy=%0b stall=%0b req=%0b exp 1 0 0",
               if_ready_o, stallreq_if_o, bus_req_o);
    end
    step();
    if_req_i = 1'b0;
    step();
    sample();
    checks++;
    if ({bus_req_o, if_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL fetch_gap got req=%0b rdy=%0b exp 0 0",
               bus_req_o, if_ready_o);
    end
  endtask

  task automatic test_lb_lbu();
    logic [31:0] exp_v;
    for (int k = 0; k < 2; k++) begin
      exp_v = (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
      step();
      mem_req_i    = 1'b1;
      mem_we_i     = 1'b0;
      mem_funct3_i = (k == 0) ? 3'd0 : 3'd4;
      mem_addr_i   = 32'h0000_0102;
      push(1'b1, 1'b1, exp_v, 1'b0);
      sample();
      checks++;
      if (stallreq_mem_o !== 1'b1) begin
        errors++;
        $display("FAIL lb_stall%0d got %0b exp 1",
                 k, stallreq_mem_o);
      end
      step();
      sample();
      checks++;
      if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 ||
          bus_sel_o !== 4'b0100 ||
          bus_addr_o !== 32'h0000_0100) begin
        errors++;
        $display({"FAIL lb_bus%0d got req=%0b we=%0b ",
                  "sel=%b addr=%h exp 1 0 0100 00000100"},
                 k, bus_req_o, bus_we_o,
                 bus_sel_o, bus_addr_o);
      end
      step();
      mem_addr_i   = 32'h0000_0FFF;
      mem_funct3_i = 3'd2;
      step();
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h1280_3456;
      sample();
      checks++;
      if (bus_req_o !== 1'b1 || mem_ready_o !== 1'b0 ||
          bus_addr_o !== 32'h0000_0100) begin
        errors++;
        $display("FAIL lb_wait%0d got req=%0b rdy=%0b addr=%h",
                 k, bus_req_o, mem_ready_o, bus_addr_o);
      end
      step();
      bus_ack_i = 1'b0;
      sample();
      checks++;
      if ({mem_ready_o, stallreq_mem_o} !== 2'b10) begin
        errors++;
        $display("FAIL lb_c4_%0d got rdy=%0b stall=%0b exp 1 0",
                 k, mem_ready_o, stallreq_mem_o);
      end
      step();
      mem_req_i = 1'b0;
    end
  endtask

  task automatic test_sh();
    step();
    mem_req_i    = 1'b1;
    mem_we_i     = 1'b1;
    mem_funct3_i = 3'd1;
    mem_addr_i   = 32'h0000_0206;
    mem_wdata_i  = 32'h1234_ABCD;
    push(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h5555_5555;
    sample();
    checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 ||
        bus_sel_o !== 4'b1100 ||
        bus_wdata_o !== 32'hABCD_ABCD ||
        bus_addr_o !== 32'h0000_0204) begin
      errors++;
      $display({"FAIL sh_bus got req=%0b we=%0b sel=%b ",
                "wd=%h addr=%h exp 1 1 1100 abcdabcd ",
                "00000204"},
               bus_req_o, bus_we_o, bus_sel_o,
               bus_wdata_o, bus_addr_o);
    end
    step();
    bus_ack_i = 1'b0;
    sample();
    checks++;
    if (mem_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL sh_ready got %0b exp 1", mem_ready_o);
    end
    step();
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
  endtask

  task automatic test_contention();
    step();
    if_req_i     = 1'b1;
    if_addr_i    = 32'h0000_0300;
    mem_req_i    = 1'b1;
    mem_we_i     = 1'b0;
    mem_funct3_i = 3'd2;
    mem_addr_i   = 32'h0000_0400;
    push(1'b1, 1'b1, 32'h1111_2222, 1'b0);
    push(1'b0, 1'b1, 32'h3333_4444, 1'b0);
    step();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h1111_2222;
    sample();
    checks++;
    if (bus_req_o !== 1'b1 ||
        bus_addr_o !== 32'h0000_0400) begin
      errors++;
      $display("FAIL cont_first got req=%0b addr=%h exp 1 00000400",
               bus_req_o, bus_addr_o);
    end
    step();
    bus_ack_i = 1'b0;
    sample();
    checks++;
    if ({mem_ready_o, stallreq_if_o} !== 2'b11) begin
      errors++;
      $display("FAIL cont_c2 got rdy=%0b stall_if=%0b exp 1 1",
               mem_ready_o, stallreq_if_o);
    end
    step();
    mem_req_i = 1'b0;
    sample();
    checks++;
    if ({bus_req_o, stallreq_if_o} !== 2'b01) begin
      errors++;
      $display("FAIL cont_c3 got req=%0b stall_if=%0b exp 0 1",
               bus_req_o, stallreq_if_o);
    end
    step();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h3333_4444;
    sample();
    checks++;
    if (bus_req_o !== 1'b1 || stallreq_if_o !== 1'b1 ||
        bus_addr_o !== 32'h0000_0300) begin
      errors++;
      $display("FAIL cont_c4 got req=%0b stall_if=%0b addr=%h",
               bus_req_o, stallreq_if_o, bus_addr_o);
    end
    step();
    bus_ack_i = 1'b0;
    sample();
    checks++;
    if ({if_ready_o, stallreq_if_o} !== 2'b10) begin
      errors++;
      $display("FAIL cont_c5 got rdy=%0b stall_if=%0b exp 1 0",
               if_ready_o, stallreq_if_o);
    end
    step();
    if_req_i = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [2:0]  f3s   [3];
    logic        wes   [3];
    addrs = '{32'h0000_0102, 32'h0000_0101, 32'h0000_0203};
    f3s   = '{3'd2, 3'd1, 3'd2};
    wes   = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      step();
      mem_req_i    = 1'b1;
      mem_we_i     = wes[k];
      mem_funct3_i = f3s[k];
      mem_addr_i   = addrs[k];
      mem_wdata_i  = 32'hFFFF_FFFF;
      push(1'b1, 1'b1, 32'h0, 1'b1);
      step();
      sample();
      checks++;
      if ({bus_req_o, bus_we_o, mem_ready_o,
           mem_err_o} !== 4'b0011) begin
        errors++;
        $display("FAIL misal%0d got req=%0b we=%0b rdy=%0b err=%0b",
                 k, bus_req_o, bus_we_o,
                 mem_ready_o, mem_err_o);
      end
      step();
      mem_req_i = 1'b0;
      sample();
      checks++;
      if (bus_req_o !== 1'b0) begin
        errors++;
        $display("FAIL misal_idle%0d got req=%0b exp 0",
                 k, bus_req_o);
      end
    end
    mem_we_i = 1'b0;
  endtask

  task automatic test_illegal_funct3();
    logic [2:0] f3s [5];
    logic       wes [5];
    f3s = '{3'd3, 3'd6, 3'd7, 3'd3, 3'd4};
    wes = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      step();
      mem_req_i    = 1'b1;
      mem_we_i     = wes[k];
      mem_funct3_i = f3s[k];
      mem_addr_i   = 32'h0000_0100;
      push(1'b1, 1'b1, 32'h0, 1'b1);
      step();
      sample();
      checks++;
      if ({bus_req_o, mem_err_o} !== 2'b01) begin
        errors++;
        $display("FAIL illegal%0d got req=%0b err=%0b exp 0 1",
                 k, bus_req_o, mem_err_o);
      end
      step();
      mem_req_i = 1'b0;
    end
    mem_we_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    mem_req_i    = 1'b1;
    mem_we_i     = 1'b0;
    mem_funct3_i = 3'd2;
    mem_addr_i   = 32'h0000_0500;
    step();
    step();
    rst = 1'b1;
    sample();
    checks++;
    if (bus_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_c2 got req=%0b exp 1", bus_req_o);
    end
    step();
    rst       = 1'b0;
    mem_req_i = 1'b0;
    sample();
    checks++;
    if (bus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_c3 got req=%0b exp 0", bus_req_o);
    end
    step();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h9999_9999;
    step();
    bus_ack_i = 1'b0;
    sample();
    checks++;
    if ({mem_ready_o, if_ready_o, bus_req_o} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_late_ack got %b exp 000",
               {mem_ready_o, if_ready_o, bus_req_o});
    end
    step();
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0600;
    push(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    step();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hCAFE_F00D;
    sample();
    checks++;
    if (bus_req_o !== 1'b1 ||
        bus_addr_o !== 32'h0000_0600) begin
      errors++;
      $display("FAIL rstmid_fetch got req=%0b addr=%h",
               bus_req_o, bus_addr_o);
    end
    step();
    bus_ack_i = 1'b0;
    sample();
    checks++;
    if (if_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_fetch_rdy got %0b exp 1",
               if_ready_o);
    end
    step();
    if_req_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_req;
    logic exp_rdy;
    push(1'b0, 1'b1, 32'hB000_0001, 1'b0);
    push(1'b0, 1'b1, 32'hB000_0004, 1'b0);
    push(1'b0, 1'b1, 32'hB000_0007, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) begin
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0700;
      end
      if (c == 8) if_req_i = 1'b0;
      exp_req     = (c == 1) || (c == 4) || (c == 7);
      exp_rdy     = (c == 2) || (c == 5) || (c == 8);
      bus_ack_i   = exp_req;
      bus_rdata_i = 32'hB000_0000 + 32'(c);
      sample();
      checks++;
      if ({bus_req_o, if_ready_o} !==
          {exp_req, exp_rdy}) begin
        errors++;
        $display("FAIL b2b_c%0d got req=%0b rdy=%0b exp %0b %0b",
                 c, bus_req_o, if_ready_o, exp_req, exp_rdy);
      end
    end
    step();
    bus_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_lb_lbu();
    test_sh();
    test_contention();
    test_misaligned();
    test_illegal_funct3();
    test_reset_mid();
    test_back_to_back();
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0",
               sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
